// File: rtl/theta_scheduler.sv
// theta_scheduler: hall-locked angular slice sequencer for the POV display.
// Measures the spin period, splits it into slices and runs one row-pair scan per slice.
module theta_scheduler #(
    parameter int ROTATIONAL_RES = 180,
    parameter int THETA_RES      = 8,
    parameter int SCAN_RATE      = 32,
    parameter int PERIOD_WIDTH   = 32,
    parameter int MIN_PERIOD     = 100000,
    parameter int MAX_PERIOD     = 200000000
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         hall_in,
    input  logic                         row_done,
    output logic [THETA_RES-1:0]         theta,
    output logic [$clog2(SCAN_RATE)-1:0] row_index,
    output logic                         row_req,
    output logic                         spinning,
    output logic                         overrun,
    output logic [PERIOD_WIDTH-1:0]      period_out
);
    localparam int ROW_W = $clog2(SCAN_RATE);
    localparam int DCW   = $clog2(PERIOD_WIDTH);
    localparam logic [PERIOD_WIDTH-1:0] MIN_M1     = PERIOD_WIDTH'(MIN_PERIOD - 1);
    localparam logic [PERIOD_WIDTH-1:0] MAX_P      = PERIOD_WIDTH'(MAX_PERIOD);
    localparam logic [PERIOD_WIDTH:0]   DIVISOR    = (PERIOD_WIDTH+1)'(ROTATIONAL_RES);
    localparam logic [THETA_RES-1:0]    THETA_LAST = THETA_RES'(ROTATIONAL_RES - 1);
    localparam logic [ROW_W-1:0]        ROW_LAST   = ROW_W'(SCAN_RATE - 1);
    localparam logic [DCW-1:0]          DIV_LAST   = DCW'(PERIOD_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_RUN} state_t;

    state_t                   state_q, state_d;
    logic                     hall_prev_q, hall_prev_d;
    logic [PERIOD_WIDTH-1:0]  period_cnt_q, period_cnt_d;
    logic [PERIOD_WIDTH-1:0]  period_out_q, period_out_d;
    logic                     div_busy_q, div_busy_d;
    logic                     div_done_q, div_done_d;
    logic [DCW-1:0]           div_cnt_q, div_cnt_d;
    logic [PERIOD_WIDTH-1:0]  div_rem_q, div_rem_d;
    logic [PERIOD_WIDTH-1:0]  div_quo_q, div_quo_d;
    logic [PERIOD_WIDTH-1:0]  slice_len_q, slice_len_d;
    logic [PERIOD_WIDTH-1:0]  slice_cnt_q, slice_cnt_d;
    logic                     pend_q, pend_d;
    logic [THETA_RES-1:0]     theta_q, theta_d;
    logic [ROW_W-1:0]         row_index_q, row_index_d;
    logic                     row_req_q, row_req_d;
    logic                     spinning_q, spinning_d;
    logic                     overrun_q, overrun_d;

    logic                     rise, timeout, from_idle, accept;
    logic                     last_row, slice_tc, step_ok;
    logic [PERIOD_WIDTH:0]    div_trial;
    logic [PERIOD_WIDTH-1:0]  div_quot;

    always_comb begin
        rise      = hall_in & ~hall_prev_q;
        timeout   = (period_cnt_q == MAX_P);
        // A timed-out block treats a coincident edge as the first edge from IDLE.
        from_idle = (state_q == S_IDLE) || timeout;
        accept    = rise && (from_idle || (period_cnt_q >= MIN_M1));
        div_trial = {div_rem_q, div_quo_q[PERIOD_WIDTH-1]};
        div_quot  = (div_quo_q == '0) ? PERIOD_WIDTH'(1) : div_quo_q;
        last_row  = (row_index_q == ROW_LAST);
        slice_tc  = (state_q == S_RUN) && (theta_q != THETA_LAST) &&
                    (slice_cnt_q == slice_len_q - 1'b1);
        step_ok   = !row_req_q || row_done;

        state_d      = state_q;
        hall_prev_d  = hall_in;
        period_cnt_d = timeout ? period_cnt_q : period_cnt_q + 1'b1;
        period_out_d = period_out_q;
        div_busy_d   = div_busy_q;
        div_done_d   = 1'b0;
        div_cnt_d    = div_cnt_q;
        div_rem_d    = div_rem_q;
        div_quo_d    = div_quo_q;
        slice_len_d  = slice_len_q;
        slice_cnt_d  = slice_cnt_q;
        pend_d       = pend_q;
        theta_d      = theta_q;
        row_index_d  = row_index_q;
        row_req_d    = row_req_q;
        spinning_d   = spinning_q;
        overrun_d    = 1'b0;

        if (accept) begin
            period_cnt_d = '0;
            period_out_d = period_cnt_q + 1'b1;
        end

        // Restoring divide, one quotient bit per cycle, MSB first.
        if (div_busy_q) begin
            if (div_trial >= DIVISOR) begin
                div_rem_d = PERIOD_WIDTH'(div_trial - DIVISOR);
                div_quo_d = {div_quo_q[PERIOD_WIDTH-2:0], 1'b1};
            end else begin
                div_rem_d = div_trial[PERIOD_WIDTH-1:0];
                div_quo_d = {div_quo_q[PERIOD_WIDTH-2:0], 1'b0};
            end
            div_cnt_d = div_cnt_q + 1'b1;
            if (div_cnt_q == DIV_LAST) begin
                div_busy_d = 1'b0;
                div_done_d = 1'b1;
            end
        end
        if (accept && !from_idle) begin
            div_busy_d = 1'b1;
            div_done_d = 1'b0;
            div_cnt_d  = '0;
            div_rem_d  = '0;
            div_quo_d  = period_cnt_q + 1'b1;
        end

        if (row_req_q && row_done) begin
            if (last_row) row_req_d   = 1'b0;
            else          row_index_d = row_index_q + 1'b1;
        end

        case (state_q)
            S_IDLE: if (accept) state_d = S_SYNC;
            S_SYNC: begin
                if (div_done_q) begin
                    state_d     = S_RUN;
                    spinning_d  = 1'b1;
                    slice_len_d = div_quot;
                    theta_d     = '0;
                    slice_cnt_d = '0;
                    row_index_d = '0;
                    row_req_d   = 1'b1;
                end
            end
            S_RUN: begin
                if (div_done_q) slice_len_d = div_quot;
                if (theta_q != THETA_LAST) slice_cnt_d = slice_tc ? '0 : slice_cnt_q + 1'b1;
                // Slice change waits for the outstanding row handshake to close.
                if (slice_tc || pend_q) begin
                    if (step_ok) begin
                        theta_d     = theta_q + 1'b1;
                        row_index_d = '0;
                        row_req_d   = 1'b1;
                        pend_d      = 1'b0;
                        overrun_d   = row_req_q && !last_row;
                    end else begin
                        pend_d = 1'b1;
                    end
                end
                if (accept) begin
                    theta_d     = '0;
                    slice_cnt_d = '0;
                    pend_d      = 1'b0;
                    row_index_d = '0;
                    row_req_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (timeout) begin
            state_d     = accept ? S_SYNC : S_IDLE;
            theta_d     = '0;
            row_index_d = '0;
            row_req_d   = 1'b0;
            spinning_d  = 1'b0;
            overrun_d   = 1'b0;
            pend_d      = 1'b0;
            slice_cnt_d = '0;
            div_busy_d  = 1'b0;
            div_done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= S_IDLE;
            hall_prev_q  <= 1'b0;
            period_cnt_q <= '0;
            period_out_q <= '0;
            div_busy_q   <= 1'b0;
            div_done_q   <= 1'b0;
            div_cnt_q    <= '0;
            div_rem_q    <= '0;
            div_quo_q    <= '0;
            slice_len_q  <= PERIOD_WIDTH'(1);
            slice_cnt_q  <= '0;
            pend_q       <= 1'b0;
            theta_q      <= '0;
            row_index_q  <= '0;
            row_req_q    <= 1'b0;
            spinning_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hall_prev_q  <= hall_prev_d;
            period_cnt_q <= period_cnt_d;
            period_out_q <= period_out_d;
            div_busy_q   <= div_busy_d;
            div_done_q   <= div_done_d;
            div_cnt_q    <= div_cnt_d;
            div_rem_q    <= div_rem_d;
            div_quo_q    <= div_quo_d;
            slice_len_q  <= slice_len_d;
            slice_cnt_q  <= slice_cnt_d;
            pend_q       <= pend_d;
            theta_q      <= theta_d;
            row_index_q  <= row_index_d;
            row_req_q    <= row_req_d;
            spinning_q   <= spinning_d;
            overrun_q    <= overrun_d;
        end
    end

    assign theta      = theta_q;
    assign row_index  = row_index_q;
    assign row_req    = row_req_q;
    assign spinning   = spinning_q;
    assign overrun    = overrun_q;
    assign period_out = period_out_q;
endmodule

// File: tb/tb_theta_scheduler.sv
// Bench for theta_scheduler: lock, glitch, timeout, overrun and mid-scan reset,
// with row handshakes and overrun pulses checked against a queue of expected events.
module tb_theta_scheduler;
    localparam int RR = 4;
    localparam int SR = 4;
    localparam int PW = 16;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          hall_in = 1'b0;
    logic          row_done = 1'b0;
    logic [7:0]    theta;
    logic [1:0]    row_index;
    logic          row_req;
    logic          spinning;
    logic          overrun;
    logic [PW-1:0] period_out;

    theta_scheduler #(
        .ROTATIONAL_RES(RR), .THETA_RES(8), .SCAN_RATE(SR), .PERIOD_WIDTH(PW),
        .MIN_PERIOD(8), .MAX_PERIOD(1000)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .hall_in(hall_in), .row_done(row_done),
        .theta(theta), .row_index(row_index), .row_req(row_req), .spinning(spinning),
        .overrun(overrun), .period_out(period_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic tick_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic hall_pulse();
        hall_in = 1'b1;
        tick();
        hall_in = 1'b0;
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_theta"}, theta, 0);
        chk({p, "_row_index"}, row_index, 0);
        chk({p, "_row_req"}, row_req, 0);
        chk({p, "_spinning"}, spinning, 0);
        chk({p, "_overrun"}, overrun, 0);
        chk({p, "_period"}, period_out, 0);
    endtask

    // Panel driver model: mode 0 answers every cycle, mode 1 answers 40 cycles after a request.
    int rd_mode = 0;
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(posedge clk_in);
            #1;
            if (rd_mode == 0) begin
                row_done = 1'b1;
                wcnt = 0;
            end else if (row_req && wcnt == 40) begin
                row_done = 1'b1;
                wcnt = 0;
            end else begin
                row_done = 1'b0;
                wcnt = row_req ? wcnt + 1 : 0;
            end
        end
    end

    typedef struct {
        int th;
        int row;
        int cy;
    } exp_t;
    exp_t sb[$];
    int   mon_mode = 0;

    // mode 1: pop on each completed handshake; mode 2: pop on each overrun pulse.
    initial begin
        exp_t       e;
        logic [7:0] prev_theta;
        logic       prev_ok;
        prev_theta = '0;
        prev_ok = 1'b1;
        forever begin
            @(negedge clk_in);
            if ((mon_mode == 1 && row_req && row_done) || (mon_mode == 2 && overrun)) begin
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sb_theta", theta, e.th);
                    chk("sb_row", row_index, e.row);
                    chk("sb_cycle", cyc, e.cy);
                    if (mon_mode == 2) chk("ovr_row_req", row_req, 1);
                end
            end
            if (mon_mode == 2 && theta != prev_theta) chk("theta_gate", prev_ok, 1);
            prev_theta = theta;
            prev_ok = !row_req || row_done;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c1, c3, m, c4, b, r, c5;
        exp_t e;

        rst_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hall_in = ~hall_in;
            tick();
        end
        chk_zero("reset");
        rst_in = 1'b1;
        hall_in = 1'b0;
        repeat (5) tick();
        chk("post_reset_spin", spinning, 0);

        // Lock: edges 400 cycles apart, driver always ready.
        hall_pulse();
        tick_until(cyc + 399);
        hall_pulse();
        c1 = cyc;
        chk("lock_period", period_out, 400);
        for (int t = 0; t < RR; t++)
            for (int k = 0; k < SR; k++) begin
                e.th = t; e.row = k; e.cy = c1 + 17 + 100 * t + k;
                sb.push_back(e);
            end
        mon_mode = 1;
        tick_until(c1 + 16);
        chk("sync_spin0", spinning, 0);
        tick();
        chk("lock_spin1", spinning, 1);
        tick_until(c1 + 17 + 350);
        chk("hold_theta3", theta, 3);
        chk("hold_req0", row_req, 0);

        // Next revolution edge resets theta; a glitch 5 cycles later is ignored.
        tick_until(c1 + 399);
        hall_pulse();
        c3 = cyc;
        chk("rev_period", period_out, 400);
        for (int t = 0; t < RR; t++)
            for (int k = 0; k < SR; k++) begin
                e.th = t; e.row = k; e.cy = c3 + 100 * t + k;
                sb.push_back(e);
            end
        tick_until(c3 + 4);
        hall_pulse();
        chk("glitch_period", period_out, 400);
        chk("glitch_theta", theta, 0);
        chk("glitch_req", row_req, 0);
        tick_until(c3 + 350);
        chk("rev_theta3", theta, 3);

        // Timeout with no further edges.
        tick_until(c3 + 990);
        chk("pre_timeout_spin", spinning, 1);
        tick_until(c3 + 1010);
        chk("timeout_spin", spinning, 0);
        chk("timeout_theta", theta, 0);
        chk("timeout_req", row_req, 0);
        chk("sb_lock_left", sb.size(), 0);

        // Relock with a slow driver: every slice overruns except the last.
        mon_mode = 0;
        rd_mode = 1;
        hall_pulse();
        m = cyc;
        tick_until(m + 30);
        chk("resync_spin", spinning, 0);
        chk("resync_req", row_req, 0);
        tick_until(m + 399);
        hall_pulse();
        c4 = cyc;
        b = c4 + 17;
        chk("ovr_period", period_out, 400);
        e.row = 0;
        e.th = 1; e.cy = b + 123; sb.push_back(e);
        e.th = 2; e.cy = b + 205; sb.push_back(e);
        e.th = 3; e.cy = b + 328; sb.push_back(e);
        mon_mode = 2;
        tick_until(b + 415);
        mon_mode = 0;
        chk("sb_ovr_left", sb.size(), 0);

        // Reset in the middle of row 2.
        tick_until(b + 420);
        chk("mid_row_index", row_index, 2);
        chk("mid_row_req", row_req, 1);
        rst_in = 1'b0;
        tick();
        chk_zero("midrst");
        rst_in = 1'b1;
        rd_mode = 0;
        tick();
        hall_pulse();
        r = cyc;
        tick_until(r + 300);
        chk("one_edge_spin", spinning, 0);
        tick_until(r + 399);
        hall_pulse();
        c5 = cyc;
        tick_until(c5 + 16);
        chk("relock_spin0", spinning, 0);
        tick();
        chk("relock_spin1", spinning, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/theta_scheduler.md
# theta_scheduler

Rotation-synchronous controller for the persistence-of-vision display. Measures the spin period from the hall sensor, divides each revolution into `ROTATIONAL_RES` angular slices, and drives the `theta` input of the frame buffer. Within each slice it sequences the `SCAN_RATE` row-pair scan through a request/done handshake with the panel driver, holding `theta` stable for the whole scan.

## Interface
- `ROTATIONAL_RES`, 180: slices per revolution.
- `THETA_RES`, 8: `theta` width; must satisfy 2^THETA_RES ≥ ROTATIONAL_RES.
- `SCAN_RATE`, 32: row pairs scanned per slice.
- `PERIOD_WIDTH`, 32: width of the period counter and divider.
- `MIN_PERIOD`, 100000: minimum cycles between accepted hall edges (glitch reject).
- `MAX_PERIOD`, 200000000: cycles without an edge before the block declares the display stopped.
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  reset; synchronous, active-low.
- `hall_in`  in  1  hall sensor, already synchronized to `clk_in`, active-high.
- `row_done`  in  1  panel driver has finished the requested row.
- `theta`  out  THETA_RES  slice index to the frame buffer; stable while a scan is in progress.
- `row_index`  out  $clog2(SCAN_RATE)  row pair currently requested.
- `row_req`  out  1  request to the panel driver to shift and latch `row_index`.
- `spinning`  out  1  period is valid and `theta` is advancing.
- `overrun`  out  1  one-cycle pulse: a slice ended before its scan completed.
- `period_out`  out  PERIOD_WIDTH  last accepted revolution period, in cycles.

## Operation
- **Edge detect:** `rise` = `hall_in` & ~`hall_prev`. The edge is accepted only when `period_cnt` ≥ MIN_PERIOD−1, or when the state is IDLE. Other edges are ignored.
- **Period counter:** `period_cnt` increments every cycle and saturates at MAX_PERIOD. On an accepted edge, `period_out` ← `period_cnt`+1 and `period_cnt` ← 0.
- **Divider:** a restoring divider computes `slice_len` = `period_out` / ROTATIONAL_RES, taking PERIOD_WIDTH cycles.
  - It starts on every accepted edge except the first edge after IDLE.
  - A quotient of 0 is forced to 1.
  - The old `slice_len` stays in use until the divide completes.
  - An edge accepted mid-divide restarts the divide with the new period.
- **State machine:**
  - IDLE: the first accepted edge goes to SYNC.
  - SYNC: the next accepted edge loads the period and starts the divider. When the divide completes, go to RUN and set `spinning`=1.
  - RUN: an accepted edge sets `theta` ← 0, clears the slice counter and starts a new scan.
  - Any state: `period_cnt` reaching MAX_PERIOD goes to IDLE.
- **Theta advance (RUN):** the slice counter counts 0..`slice_len`−1.
  - At terminal count, `theta` increments and a new scan starts.
  - At ROTATIONAL_RES−1, `theta` saturates and the counter halts; there is no wrap without a hall edge.
- **Scan engine:** on scan start, `row_index` ← 0 and `row_req` ← 1.
  - `row_req` is held until a cycle with `row_done`=1.
  - The next cycle either requests `row_index`+1, or drops `row_req` after row SCAN_RATE−1.
  - A new slice arriving while a row is outstanding:
    - the current handshake completes and the remaining rows are abandoned;
    - `overrun` pulses on the slice-change cycle;
    - `theta` updates and row 0 is requested the cycle after `row_done`.
  - `theta` only changes in a cycle where `row_req`=0 or `row_done`=1; a pending increment waits for that.
- **IDLE entry:** `theta` ← 0, `row_req` ← 0, `spinning` ← 0, divider aborted. `period_out` is kept.

## Timing
- **Reset values:** every output is 0, state IDLE, `slice_len` = 1, `hall_prev` = 0.
- **Hall edge:** `rise` in cycle N produces `theta`=0, `period_out` update and divider start, all visible in N+1.
- **Divider:** the result is registered PERIOD_WIDTH+1 cycles after the accepted edge. `spinning` rises in that same cycle when in SYNC.
- **Theta step:** `theta` changes the cycle after terminal count, with `row_req`=1 and `row_index`=0 in the same cycle.
- **Handshake:** `row_done` sampled high in cycle M gives the next `row_index` with `row_req` still 1 in M+1. A driver that asserts `row_done` every cycle yields one row per cycle.
- **Simultaneous events:**
  - Accepted edge coinciding with terminal count: the edge wins (`theta`=0).
  - Accepted edge coinciding with `row_done` on the last row: the new scan starts.
  - Timeout coinciding with an edge: the edge is accepted from IDLE and the state goes to SYNC.
- **Reset mid-operation:** takes effect on the next edge of `clk_in`; `row_req` drops even if a handshake is outstanding.

## Test plan
All scenarios use ROTATIONAL_RES=4, SCAN_RATE=4, PERIOD_WIDTH=16, MIN_PERIOD=8, MAX_PERIOD=1000.
- **Reset:** hold `rst_in`=0 for 3 cycles with `hall_in` toggling → all outputs 0, `hall_in` ignored.
- **Lock:** edges at t=10 and t=410, `row_done` tied to 1 → `period_out`=400, `spinning`=1 at t=428, `slice_len`=100.
  - `theta` steps 0→1→2→3 every 100 cycles and holds at 3.
  - Each slice issues `row_index` 0,1,2,3 on consecutive cycles.
- **Glitch reject:** in RUN, an extra rise 5 cycles after an accepted edge → ignored; `period_out` and `theta` unchanged.
- **Timeout:** stop edges after lock → 1000 cycles later `spinning`=0, `theta`=0, `row_req`=0. The next edge enters SYNC only.
- **Overrun:** lock at period 400, `row_done` asserted 40 cycles after each `row_req` → `overrun` pulses once per slice.
  - `theta` changes only on a `row_done` cycle.
  - Row 0 restarts the next cycle.
- **Reset mid-scan:** `rst_in`=0 while `row_req`=1 and `row_index`=2 → next cycle all outputs 0. After release, two edges are required before `spinning` rises again.
